// File: rtl/fft_bf_sequencer_if.sv
`default_nettype none
// fft_bf_sequencer_if: frame-start handshake and butterfly issue/complete bus.
// slave = sequencer side, master = environment side. FFT_SEQ_CYCLE_CNT_EN adds cycles_o.
interface fft_bf_sequencer_if;
  logic       valid_i;
  logic       ready_o;
  logic       bf_valid_o;
  logic       bf_ready_i;
  logic [3:0] bf_addr_a_o;
  logic [3:0] bf_addr_b_o;
  logic [2:0] bf_tw_idx_o;
  logic [1:0] bf_stage_o;
  logic       bf_done_i;
  logic       busy_o;
  logic       done_o;
`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [7:0] cycles_o;

  modport slave (
    input  valid_i, bf_ready_i, bf_done_i,
    output ready_o, bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_idx_o,
           bf_stage_o, busy_o, done_o, cycles_o
  );

  modport master (
    output valid_i, bf_ready_i, bf_done_i,
    input  ready_o, bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_idx_o,
           bf_stage_o, busy_o, done_o, cycles_o
  );
`else
  modport slave (
    input  valid_i, bf_ready_i, bf_done_i,
    output ready_o, bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_idx_o,
           bf_stage_o, busy_o, done_o
  );

  modport master (
    output valid_i, bf_ready_i, bf_done_i,
    input  ready_o, bf_valid_o, bf_addr_a_o, bf_addr_b_o, bf_tw_idx_o,
           bf_stage_o, busy_o, done_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fft_bf_sequencer.sv
`default_nettype none
// fft_bf_sequencer: schedules one radix-2 butterfly unit through a 16-point DIT FFT
// (4 stages x 8 butterflies). Optional FFT_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter.
module fft_bf_sequencer #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  fft_bf_sequencer_if.slave        bus
);

  localparam logic [2:0] MAX_IF = MAX_INFLIGHT[2:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [1:0] stage, stage_n;
  logic [2:0] j, j_n;
  logic [2:0] inflight, inflight_n;
  logic       err;

  logic       ready, bf_valid, busy, done;
  logic [3:0] addr_a, addr_b;
  logic [2:0] tw_idx;
  logic       valid_n;
  logic [10:0] tuple_n;

  logic issue, done_ok, spurious, start;

  // Packs {addr_a, addr_b, tw_idx} for butterfly jj of stage s.
  function automatic logic [10:0] bf_tuple(input logic [1:0] s, input logic [2:0] jj);
    logic [2:0] mask, pos, grp, tw;
    logic [3:0] span, a, b;
    span = 4'd1 << s;
    mask = 3'(span - 4'd1);
    pos  = jj & mask;
    grp  = jj >> s;
    a    = ({1'b0, grp} << ({1'b0, s} + 3'd1)) | {1'b0, pos};
    b    = a + span;
    tw   = pos << (2'd3 - s);
    return {a, b, tw};
  endfunction

  assign issue    = bf_valid & bus.bf_ready_i;
  assign spurious = bus.bf_done_i & (inflight == 3'd0);
  assign done_ok  = bus.bf_done_i & (inflight != 3'd0);
  assign start    = (state == IDLE) & bus.valid_i;

  always_comb begin
    state_n    = state;
    stage_n    = stage;
    j_n        = j;
    inflight_n = inflight;

    case ({issue, done_ok})
      2'b10:   inflight_n = inflight + 3'd1;
      2'b01:   inflight_n = inflight - 3'd1;
      default: inflight_n = inflight;
    endcase

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = ISSUE;
          stage_n    = 2'd0;
          j_n        = 3'd0;
          inflight_n = 3'd0;
        end
      end
      ISSUE: begin
        if (issue) begin
          j_n = j + 3'd1;
          if (j == 3'd7) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Barrier: the next stage reads results that are still being written back.
        if (inflight == 3'd0) begin
          if (stage != 2'd3) begin
            stage_n = stage + 2'd1;
            j_n     = 3'd0;
            state_n = ISSUE;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    valid_n = (state_n == ISSUE) && (inflight_n < MAX_IF);
    tuple_n = bf_tuple(stage_n, j_n);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      stage    <= 2'd0;
      j        <= 3'd0;
      inflight <= 3'd0;
      err      <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      addr_a   <= 4'd0;
      addr_b   <= 4'd0;
      tw_idx   <= 3'd0;
    end else begin
      state    <= state_n;
      stage    <= stage_n;
      j        <= j_n;
      inflight <= inflight_n;
      err      <= err | spurious;
      ready    <= (state_n == IDLE);
      busy     <= (state_n == ISSUE) || (state_n == DRAIN);
      done     <= (state_n == DONE);
      bf_valid <= valid_n;
      {addr_a, addr_b, tw_idx} <= tuple_n;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.bf_valid_o  = bf_valid;
  assign bus.bf_addr_a_o = addr_a;
  assign bus.bf_addr_b_o = addr_b;
  assign bus.bf_tw_idx_o = tw_idx;
  assign bus.bf_stage_o  = stage;

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [7:0] cycles;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycles <= 8'd0;
    end else if (start) begin
      cycles <= 8'd0;
    end else if (busy && cycles != 8'hFF) begin
      cycles <= cycles + 8'd1;
    end
  end

  assign bus.cycles_o = cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bf_sequencer.sv
`default_nettype none
// tb_fft_bf_sequencer: randomized bench with a frame-level reference model of the
// FFT butterfly schedule, in-flight accounting and frame timing.
module tb_fft_bf_sequencer;

  localparam int MAX_INFLIGHT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_bf_sequencer_if bus();

  fft_bf_sequencer #(.MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = -10;
  int issued = 0;
  int outstanding = 0;
  int frames_done = 0;
  int exp_cycles = 0;
  bit in_frame = 0;
  int due_q[$];
  bit stalled = 0;
  int prev_a, prev_b, prev_tw, prev_st;

  // Scenario knobs
  int ready_mode = 0;
  int lat = 2;
  bit lat_rand = 0;
  bit lat_check = 0;
  int hold_until = 0;
  int limit_chk_cyc = -10;
  int spurious_cyc = -10;
  int stall_until = 0;
  bit valid_req = 0;
  bit valid_hold = 0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Butterfly j of stage s: pairs are 2*span apart in groups, twiddle step 8/span.
  function automatic void ref_tuple(input int s, input int jj, output int a, output int b, output int tw);
    int span, pos, grp;
    span = 1 << s;
    pos  = jj % span;
    grp  = jj / span;
    a    = grp * 2 * span + pos;
    b    = a + span;
    tw   = pos * (8 / span);
  endfunction

  function automatic bit pick_ready();
    case (ready_mode)
      1:       return (issued / 8 == 1) ? cyc[0] : 1'b1;
      2:       return $urandom_range(0, 3) != 0;
      3:       return cyc >= stall_until;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    int a, b, tw;
    bit rdy, dn, accept;
    @(negedge clk);
    cyc++;

    check("ready_o", bus.ready_o, int'(!in_frame));
    check("busy_o", bus.busy_o, int'(in_frame && !bus.done_o));

`ifdef FFT_SEQ_CYCLE_CNT_EN
    if (cyc == done_cyc + 1) check("cycles_held", bus.cycles_o, exp_cycles);
`endif

    if (cyc == limit_chk_cyc) check("limit_issues", issued, MAX_INFLIGHT);
    if (cyc == limit_chk_cyc + 1) check("limit_resume_valid", bus.bf_valid_o, 1);

    if (bus.done_o) begin
      check("done_in_frame", int'(in_frame), 1);
      check("done_issued", issued, 32);
      check("done_outstanding", outstanding, 0);
      if (lat_check) check("frame_cycles", cyc - acc_cyc + 1, 4 * (8 + lat + 1) + 2);
      exp_cycles = (cyc - acc_cyc - 1 > 255) ? 255 : cyc - acc_cyc - 1;
`ifdef FFT_SEQ_CYCLE_CNT_EN
      check("cycles_o", bus.cycles_o, exp_cycles);
`endif
      in_frame = 0;
      frames_done++;
      done_cyc = cyc;
    end

    rdy = pick_ready();
    if (stalled) begin
      check("stall_valid_held", bus.bf_valid_o, 1);
      if (bus.bf_valid_o) begin
        check("stall_addr_a", bus.bf_addr_a_o, prev_a);
        check("stall_addr_b", bus.bf_addr_b_o, prev_b);
        check("stall_tw", bus.bf_tw_idx_o, prev_tw);
        check("stall_stage", bus.bf_stage_o, prev_st);
      end
    end
    if (bus.bf_valid_o) begin
      check("valid_in_frame", int'(in_frame), 1);
      check("valid_under_cap", int'(outstanding < MAX_INFLIGHT), 1);
      if (rdy) begin
        check("issue_count", int'(issued < 32), 1);
        if (issued < 32) begin
          ref_tuple(issued / 8, issued % 8, a, b, tw);
          check("issue_addr_a", bus.bf_addr_a_o, a);
          check("issue_addr_b", bus.bf_addr_b_o, b);
          check("issue_tw", bus.bf_tw_idx_o, tw);
          check("issue_stage", bus.bf_stage_o, issued / 8);
          if (issued % 8 == 0 && issued > 0) check("stage_barrier", outstanding, 0);
        end
        issued++;
        outstanding++;
        due_q.push_back(cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat));
      end
      stalled = !rdy;
      prev_a  = bus.bf_addr_a_o;
      prev_b  = bus.bf_addr_b_o;
      prev_tw = bus.bf_tw_idx_o;
      prev_st = bus.bf_stage_o;
    end else begin
      stalled = 0;
    end
    bus.bf_ready_i = rdy;

    // One write-back per cycle at most, in issue order.
    dn = 0;
    if (cyc == spurious_cyc) begin
      dn = 1;
    end else if (due_q.size() > 0 && due_q[0] <= cyc && cyc >= hold_until) begin
      dn = 1;
      void'(due_q.pop_front());
      outstanding--;
    end
    bus.bf_done_i = dn;

    accept = valid_req && !in_frame && cyc != done_cyc;
    bus.valid_i = valid_req;
    if (accept) begin
      in_frame = 1;
      acc_cyc  = cyc;
      issued   = 0;
      if (!valid_hold) valid_req = 0;
    end
  endtask

  task automatic run_frame(input int budget);
    int start_frames;
    start_frames = frames_done;
    for (int i = 0; i < budget && frames_done == start_frames; i++) step();
    if (frames_done == start_frames) check("frame_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.bf_ready_i = 1'b0;
    bus.bf_done_i = 1'b0;
    @(negedge clk);
    cyc++;
    check("rst_ready", bus.ready_o, 1);
    check("rst_busy", bus.busy_o, 0);
    check("rst_bf_valid", bus.bf_valid_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_addr_a", bus.bf_addr_a_o, 0);
    check("rst_addr_b", bus.bf_addr_b_o, 0);
    check("rst_tw", bus.bf_tw_idx_o, 0);
    check("rst_stage", bus.bf_stage_o, 0);
`ifdef FFT_SEQ_CYCLE_CNT_EN
    check("rst_cycles", bus.cycles_o, 0);
`endif
    rst_n = 1'b1;
    in_frame = 0;
    issued = 0;
    outstanding = 0;
    due_q.delete();
    stalled = 0;
    valid_req = 0;
  endtask

  task automatic set_mode(input int mode, input int l, input bit rnd, input bit lchk);
    ready_mode = mode;
    lat = l;
    lat_rand = rnd;
    lat_check = lchk;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.bf_ready_i = 1'b0;
    bus.bf_done_i = 1'b0;
    do_reset();

    // Spurious write-back while idle must not disturb anything visible.
    spurious_cyc = cyc + 2;
    for (int i = 0; i < 5; i++) step();

    // Ideal unit, latency 2, then latency 3 (issue and done coincide at inflight 3).
    set_mode(0, 2, 0, 1);
    valid_req = 1;
    run_frame(200);
    for (int i = 0; i < 3; i++) step();
    set_mode(0, 3, 0, 1);
    valid_req = 1;
    run_frame(200);

    // Backpressure toggling through stage 1.
    set_mode(1, 2, 0, 0);
    valid_req = 1;
    run_frame(300);

    // In-flight limit: write-backs withheld for 10 cycles after the frame starts.
    set_mode(0, 2, 0, 0);
    hold_until = cyc + 1 + 10;
    limit_chk_cyc = hold_until;
    valid_req = 1;
    run_frame(300);
    hold_until = 0;
    limit_chk_cyc = -10;

    // valid_i held high: back-to-back frames, no queuing.
    set_mode(0, 2, 0, 1);
    valid_hold = 1;
    valid_req = 1;
    run_frame(200);
    run_frame(200);
    valid_hold = 0;
    valid_req = 0;
    for (int i = 0; i < 3; i++) step();

    // Random backpressure and random butterfly latency.
    set_mode(2, 2, 1, 0);
    for (int f = 0; f < 3; f++) begin
      valid_req = 1;
      run_frame(600);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
    end

    // Long stall so the busy-cycle count saturates.
    set_mode(3, 2, 0, 0);
    stall_until = cyc + 300;
    valid_req = 1;
    run_frame(1000);

    // Reset in the middle of stage 2, then a clean frame.
    set_mode(0, 2, 0, 0);
    valid_req = 1;
    for (int i = 0; i < 200 && issued < 19; i++) step();
    check("reached_stage2", int'(issued >= 19), 1);
    do_reset();
    set_mode(0, 2, 0, 1);
    valid_req = 1;
    run_frame(200);
    for (int i = 0; i < 3; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bf_sequencer.md
# fft_bf_sequencer

Controller that schedules one shared radix-2 butterfly unit through a full 16-point decimation-in-time FFT: 4 stages × 8 butterflies = 32 operations. It sits between the sample buffer and the butterfly datapath. For each operation it issues operand addresses and a twiddle index, tracks butterflies in flight, and blocks the next stage until every result of the current stage has been written back. It signals frame completion to the output stage.

## Interface
Parameters:
- MAX_INFLIGHT, 4, maximum issued butterflies without a matching bf_done_i (1..7).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- valid_i  in  1  frame-start request; accepted only when ready_o=1.
- ready_o  out  1  high in IDLE only.
- bf_valid_o  out  1  butterfly issue strobe.
- bf_ready_i  in  1  butterfly unit can accept; an issue occurs when bf_valid_o & bf_ready_i.
- bf_addr_a_o  out  4  upper-leg sample address.
- bf_addr_b_o  out  4  lower-leg sample address.
- bf_tw_idx_o  out  3  twiddle index k of W16^k (0..7).
- bf_stage_o  out  2  current stage 0..3.
- bf_done_i  in  1  one write-back completed; one pulse per issued butterfly.
- busy_o  out  1  high from start acceptance until done_o.
- done_o  out  1  one-cycle pulse when the last stage-3 result is written back.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ready_o=1.
  - valid_i=1 → ISSUE; stage=0, j=0, inflight=0.
- ISSUE:
  - bf_valid_o=1 while inflight<MAX_INFLIGHT.
  - Each handshake: j increments and inflight increments.
  - After the handshake with j=7 → DRAIN.
- DRAIN:
  - bf_valid_o=0.
  - When inflight=0 and stage<3 → stage increments, j=0, → ISSUE.
  - When inflight=0 and stage=3 → DONE.
- DONE: done_o=1 for one cycle, then → IDLE.
- Address generation for stage s and butterfly j:
  - span=1<<s, pos=j&(span-1), grp=j>>s.
  - addr_a=grp·2·span+pos; addr_b=addr_a+span.
  - tw_idx=pos<<(3−s).
  - Stage 0 yields (0,1,k0),(2,3,k0)…; stage 3 yields (j, j+8, kj).
- Inflight counter:
  - Issue alone: +1. bf_done_i alone: −1. Both in the same cycle: unchanged.
  - Width 3 bits.
- bf_done_i with inflight=0 (spurious): ignored. The counter saturates at 0 and the sticky error flag err_q sets. err_q is internal; it clears only on reset.
- valid_i while busy: ignored, no queuing.
- Outputs remain stable while bf_valid_o=1 and bf_ready_i=0.
- Reset mid-frame: all state returns to IDLE on the next edge; in-flight completions are lost (owner must reset the datapath together).

## Timing
- Reset values:
  - ready_o=1.
  - busy_o=0, bf_valid_o=0, done_o=0.
  - bf_addr_a_o=0, bf_addr_b_o=0, bf_tw_idx_o=0, bf_stage_o=0.
- All outputs are registered.
- Start handshake at edge N → bf_valid_o=1 with stage 0, j=0 at cycle N+1.
- Full throughput: one issue per cycle when bf_ready_i=1 and the inflight limit is not hit.
- Stage barrier: the first issue of stage s+1 appears the cycle after the cycle in which inflight reaches 0 in DRAIN.
- done_o asserts the cycle after the DRAIN exit of stage 3. busy_o deasserts in the same cycle as the done_o pulse.
- ready_o rises the cycle after done_o.
- Minimum frame, with butterfly latency L and MAX_INFLIGHT≥L: 4·(8+L+1)+2 cycles from acceptance to done_o.

## Configuration
- FFT_SEQ_CYCLE_CNT_EN defined:
  - Adds output cycles_o [7:0]. It counts clock cycles while busy_o=1 and saturates at 255.
  - It clears on start acceptance and holds its value after done_o until the next start.
  - Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- Ideal unit: bf_ready_i=1, bf_done_i 2 cycles after each issue, MAX_INFLIGHT=4 → 32 issues, exact address/twiddle sequence per formula, done_o after 4·11+2=46 cycles.
- Backpressure: bf_ready_i toggling 1/0 every cycle in stage 1 → outputs held while stalled, no issue lost or duplicated, stage-1 tuples (0,2,0),(1,3,4),(4,6,0),…
- Inflight limit: bf_done_i withheld for 10 cycles, MAX_INFLIGHT=4 → exactly 4 issues, then bf_valid_o=0 until the first bf_done_i.
- Simultaneous issue and done at inflight=3 → counter stays 3; stage barrier still waits for 0.
- valid_i held high through the frame → only one frame runs; a second frame starts the cycle after ready_o returns.
- rst_ni low in stage 2 ISSUE → the next cycle shows all reset values; a new frame then starts cleanly at stage 0.
